// File: rtl/cmp_table_loader_pkg.sv
// rtl/cmp_table_loader_pkg.sv - shared widths and sequencer state encoding for the comparator table loader
package cmp_table_loader_pkg;

  localparam int HASH_W_DEF  = 35;
  localparam int ADDR_W_DEF  = 12;
  localparam int N_CORES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } ld_state_e;

  // Cores stay frozen from the start of a load until it completes, and forever after a fault.
  function automatic logic holds_cores(ld_state_e s);
    return (s == ST_HOLD) || (s == ST_WRITE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/cmp_table_loader_idle.sv
// rtl/cmp_table_loader_idle.sv - all_idle_filter: all cores idle for two consecutive cycles while enabled
module all_idle_filter
  import cmp_table_loader_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [N_CORES-1:0] core_idle_i,
  output logic               ok_o
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || !(&core_idle_i)) begin
      cnt_d = 2'd0;
    end else if (cnt_q != 2'd2) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ok_o = (cnt_q == 2'd2);

endmodule

// File: rtl/cmp_table_loader.sv
// rtl/cmp_table_loader.sv - freezes comparator cores, copies a sorted hash config into the table RAM, releases cores
module cmp_table_loader
  import cmp_table_loader_pkg::*;
#(
  parameter int HASH_W  = HASH_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int N_CORES = N_CORES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_cmp_config,
  input  logic               cfg_empty,
  output logic               cfg_rd_en,
  input  logic               cfg_hash_valid,
  input  logic               cfg_hash_end,
  input  logic [HASH_W-1:0]  cfg_hash,
  input  logic [ADDR_W-1:0]  cfg_hash_addr,
  input  logic [N_CORES-1:0] core_idle,
  output logic [N_CORES-1:0] core_hold,
  output logic               ram_wr_en,
  output logic [ADDR_W-1:0]  ram_wr_addr,
  output logic [HASH_W:0]    ram_wr_data,
  output logic               config_applied,
  output logic               table_ready,
  output logic               error
);

  ld_state_e          state_q, state_d;
  logic               new_q;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  exp_q, exp_d;
  logic               wrapped_q, wrapped_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [HASH_W:0]    wr_data_q, wr_data_d;
  logic [N_CORES-1:0] hold_q;
  logic               applied_q, ready_q, error_q;
  logic               cfg_edge, idle_ok;

  // new_q resets to 0, so a level already high out of reset is seen as an edge.
  assign cfg_edge = new_cmp_config & ~new_q;

  all_idle_filter #(
    .N_CORES (N_CORES)
  ) u_idle_filter (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == ST_HOLD),
    .core_idle_i (core_idle),
    .ok_o        (idle_ok)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    exp_d     = exp_q;
    wrapped_d = wrapped_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cfg_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_edge || pending_q) begin
          state_d   = ST_HOLD;
          pending_d = 1'b0;
        end
      end
      ST_HOLD: begin
        exp_d     = '0;
        wrapped_d = 1'b0;
        if (idle_ok) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cfg_rd_en = ~cfg_empty & ~rst;
        if (cfg_rd_en) begin
          // Rows must arrive densely from address 0; anything else corrupts the table.
          if ((cfg_hash_addr != exp_q) || (wrapped_q && !cfg_hash_end)) begin
            state_d = ST_ERROR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cfg_hash_addr;
            wr_data_d = {cfg_hash_valid, cfg_hash};
            exp_d     = exp_q + ADDR_W'(1);
            if (exp_q == '1) wrapped_d = 1'b1;
            if (cfg_hash_end) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (cfg_edge) pending_d = 1'b1;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      new_q     <= 1'b0;
      pending_q <= 1'b0;
      exp_q     <= '0;
      wrapped_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= '0;
      applied_q <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_q     <= new_cmp_config;
      pending_q <= pending_d;
      exp_q     <= exp_d;
      wrapped_q <= wrapped_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= {N_CORES{holds_cores(state_d)}};
      applied_q <= (state_d == ST_DONE);
      ready_q   <= (state_d == ST_DONE) || (ready_q && (state_d == ST_IDLE));
      error_q   <= (state_d == ST_ERROR);
    end
  end

  assign core_hold      = hold_q;
  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign config_applied = applied_q;
  assign table_ready    = ready_q;
  assign error          = error_q;

endmodule

// File: doc/cmp_table_loader.md
# cmp_table_loader

Sequencer between the comparator configuration stream and the shared comparator hash table RAM in the descrypt design. On each new comparator configuration it freezes every comparator core that reads the table and waits for all of them to drain. It then copies the incoming sorted hash rows into the table RAM and releases the cores. When the table is consistent it returns `config_applied` so the next packet can proceed.

## Interface
- `HASH_W`, 35: hash width in bits, excluding the valid bit.
- `ADDR_W`, 12: table address width; the table has 2**ADDR_W rows.
- `N_CORES`, 4: number of comparator cores sharing the table.
- `clk`  in  1  single clock for the whole block (the comparator clock).
- `rst`  in  1  reset, synchronous, active-high.
- `new_cmp_config`  in  1  level signal, already synchronized; high while an incoming config is pending.
- `cfg_empty`  in  1  config row source is empty.
- `cfg_rd_en`  out  1  pops one row; the row fields are valid whenever `cfg_empty`=0.
- `cfg_hash_valid`  in  1  row valid bit.
- `cfg_hash_end`  in  1  last row of this config.
- `cfg_hash`  in  HASH_W  hash value.
- `cfg_hash_addr`  in  ADDR_W  row address.
- `core_idle`  in  N_CORES  core i has no table lookup in flight.
- `core_hold`  out  N_CORES  core i must not start new lookups.
- `ram_wr_en`  out  1  table write strobe.
- `ram_wr_addr`  out  ADDR_W  table write address.
- `ram_wr_data`  out  HASH_W+1  table row: {valid, hash}.
- `config_applied`  out  1  one-cycle pulse when the table load is complete.
- `table_ready`  out  1  the table holds a complete configuration.
- `error`  out  1  sticky protocol error.

## Operation
- States: IDLE, HOLD, WRITE, DONE, ERROR.
- IDLE:
  - `core_hold`=0 and `cfg_rd_en`=0.
  - A rising edge of `new_cmp_config`, found by comparing it with a 1-cycle-delayed copy, moves to HOLD.
  - A level that is already high out of reset counts as an edge.
- HOLD:
  - `core_hold` is all ones and `table_ready`=0.
  - The expected-address counter is cleared.
  - Moves to WRITE after `core_idle` has been all ones for 2 consecutive cycles; the 2 cycles cover a lookup issued in the same cycle the hold asserted.
- WRITE:
  - `cfg_rd_en` = ~`cfg_empty`; one row is popped per cycle maximum.
  - On a pop:
    - `ram_wr_data` is registered as {`cfg_hash_valid`, `cfg_hash`}.
    - `ram_wr_addr` is registered as `cfg_hash_addr`.
    - `ram_wr_en` goes high on the next cycle.
    - The expected counter increments.
  - `cfg_hash_addr` must equal the expected counter. On a mismatch, the row is not written and the state goes to ERROR.
  - A pop with `cfg_hash_end`=1 moves to DONE.
  - The expected counter wraps modulo 2**ADDR_W. Popping a row after wrap-around without `cfg_hash_end` is an ERROR.
- DONE, one cycle:
  - `config_applied`=1, `core_hold`=0, `table_ready`=1, then IDLE.
  - A further `new_cmp_config` edge seen in DONE is captured and causes a HOLD right after IDLE.
- ERROR:
  - `error`=1, `core_hold` stays all ones, `cfg_rd_en`=0, `table_ready`=0.
  - Left only by `rst`.
- Reset:
  - Forces IDLE, clears the edge detector and expected counter, and drops every output to 0, regardless of state.
  - Reset during WRITE leaves the table partially written; `table_ready`=0 marks this.

## Timing
- Reset values: `core_hold`=0, `cfg_rd_en`=0, `ram_wr_en`=0, `ram_wr_addr`=0, `ram_wr_data`=0, `config_applied`=0, `table_ready`=0, `error`=0.
- `core_hold` rises 1 cycle after the `new_cmp_config` edge is sampled.
- The first pop happens at the earliest 3 cycles after `core_hold` rises.
- Table write latency is 1 cycle after `cfg_rd_en`. Back-to-back pops give 1 write per cycle.
- `config_applied` is high for exactly 1 cycle, 1 cycle after the last pop. This is the same cycle the last `ram_wr_en` is high and the cycle in which `core_hold` falls.
- `cfg_rd_en` is combinational from `cfg_empty` and the state. All other outputs are registered.

## Structure
- The shared descrypt include owns the state encoding constants and the HASH_W/ADDR_W defaults, which are derived from the existing hash and RAM address width macros.
- One natural sub-module, `all_idle_filter`: AND-reduces `core_idle` and requires 2 consecutive cycles high; clears on `rst` or on leaving HOLD.
- FSM, edge detector, expected counter and output registers live in the top module.

## Test plan
- Basic load, N_CORES=4:
  - Stimulus: all cores idle; `new_cmp_config` rises; 3 rows at addresses 0,1,2, with hashes 0x1,0x5,0x9 and end on row 2.
  - Required: table writes of {1,0x1}@0, {1,0x5}@1, {1,0x9}@2 on consecutive cycles; `config_applied` is one pulse coincident with the @2 write; `table_ready`=1.
- Drain wait:
  - Stimulus: `core_idle`=4'b1011 for 10 cycles, then 4'b1111.
  - Required: no `cfg_rd_en` until 2 cycles after all ones; `core_hold`=4'b1111 throughout.
- Gapped source:
  - Stimulus: `cfg_empty` toggles every other cycle over 4 rows.
  - Required: exactly 4 writes, at addresses 0..3, each 1 cycle after its pop.
- Address error:
  - Stimulus: rows at addresses 0,1,3.
  - Required: 2 writes; `error`=1 after the row at address 3 is popped; no further pops; `core_hold` stays high until `rst`.
- Reset mid-load:
  - Stimulus: `rst` pulsed after 2 of 5 rows are popped.
  - Required: all outputs 0 in the next cycle; a new `new_cmp_config` edge restarts the load at address 0.
- Back-to-back configs:
  - Stimulus: the `new_cmp_config` edge for config 2 arrives during DONE of config 1.
  - Required: HOLD is entered 1 cycle after IDLE; two `config_applied` pulses total.
